// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: initiator side of the external 128-bit memory bus.
// Takes one line-sized read or write over a valid/ready handshake, runs a
// single mclk high/low pulse with the memory acting on the falling edge,
// and returns a one-cycle rsp_valid pulse (read data registered).
// Optional feature: define MEMCTL_ALIGN_CHECK_EN to answer requests whose
// req_addr[3:0] != 0 with rsp_err=1 and no bus cycle.
module mem_bus_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 128,
  parameter int MCLK_HALF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr_sel,
  inout  logic [DATA_W-1:0] mem_dat,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mclk
);

  if (MCLK_HALF < 1 || MCLK_HALF > 15) begin : g_bad_mclk_half
    $error("mem_bus_ctrl: MCLK_HALF must be within 1..15");
  end

`ifdef MEMCTL_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam logic [3:0] HALF_M1 = 4'(MCLK_HALF - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETUP   = 3'd1;
  localparam logic [2:0] S_HIGH    = 3'd2;
  localparam logic [2:0] S_LOW     = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_RESP    = 3'd5;

  logic [2:0]        state;
  logic [3:0]        half_cnt;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              dat_oe;
  logic              misaligned;

  // Misaligned lines are only trapped when the alignment check is built in.
  assign misaligned = ALIGN_CHECK && (req_addr[3:0] != 4'h0);

  // The data bus is driven from registers only, and only on writes between
  // SETUP and CAPTURE; otherwise it is released for the memory.
  assign mem_dat = dat_oe ? wdata_q : {DATA_W{1'bz}};

  // Request sequencer: every output is a register loaded with the value
  // belonging to the state being entered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      state        <= S_IDLE;
      half_cnt     <= 4'd0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      dat_oe       <= 1'b0;
      req_ready    <= 1'b1;
      busy         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      mem_addr_sel <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      mclk         <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (misaligned) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              state        <= S_SETUP;
              rsp_err      <= 1'b0;
              mem_addr_sel <= req_addr;
              mem_en       <= 1'b1;
              mem_re       <= !req_we;
              mem_we       <= req_we;
              dat_oe       <= req_we;
            end
          end
        end
        S_SETUP: begin
          state    <= S_HIGH;
          mclk     <= 1'b1;
          half_cnt <= HALF_M1;
        end
        S_HIGH: begin
          if (half_cnt == 4'd0) begin
            state    <= S_LOW;
            mclk     <= 1'b0;
            half_cnt <= HALF_M1;
          end else begin
            half_cnt <= half_cnt - 4'd1;
          end
        end
        S_LOW: begin
          if (half_cnt == 4'd0) state <= S_CAPTURE;
          else                  half_cnt <= half_cnt - 4'd1;
        end
        S_CAPTURE: begin
          if (!we_q) rsp_rdata <= mem_dat;
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          mem_en    <= 1'b0;
          mem_re    <= 1'b0;
          mem_we    <= 1'b0;
          dat_oe    <= 1'b0;
        end
        S_RESP: begin
          state        <= S_IDLE;
          req_ready    <= 1'b1;
          busy         <= 1'b0;
          mem_addr_sel <= '0;
        end
        default: begin
          state        <= S_IDLE;
          req_ready    <= 1'b1;
          busy         <= 1'b0;
          mem_addr_sel <= '0;
          mem_en       <= 1'b0;
          mem_re       <= 1'b0;
          mem_we       <= 1'b0;
          dat_oe       <= 1'b0;
          mclk         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven bench with a scoreboard for mem_bus_ctrl.
// Contains a byte-addressed memory model that acts on the falling edge of
// mclk and drives mem_dat while mem_re is high.
module tb_mem_bus_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
`ifdef MEMCTL_ALIGN_CHECK_EN
  localparam int MCLK_HALF = 3;
  localparam bit ALIGN_EN  = 1'b1;
`else
  localparam int MCLK_HALF = 1;
  localparam bit ALIGN_EN  = 1'b0;
`endif
  // Edges from the accept edge to the edge that raises rsp_valid.
  localparam int LAT = 2 + 2 * MCLK_HALF;

  localparam logic [127:0] V0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [127:0] DB = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
  localparam logic [127:0] W2 = 128'h11223344_55667788_99AABBCC_DDEEFF00;
  localparam logic [127:0] V3 = 128'h00000000_00000000_0F0E0D0C_0B0A0908;
  localparam logic [127:0] V6 = 128'h0F0E0D0C_0B0A0908_11223344_55667788;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              req_ready, rsp_valid, rsp_err, busy;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr_sel;
  logic              mem_en, mem_we, mem_re, mclk;
  wire  [DATA_W-1:0] mem_dat;

  mem_bus_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MCLK_HALF(MCLK_HALF)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mem_addr_sel(mem_addr_sel), .mem_dat(mem_dat),
    .mem_en(mem_en), .mem_we(mem_we), .mem_re(mem_re), .mclk(mclk)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory model ----------------
  logic [7:0]        mem [logic [31:0]];
  logic [DATA_W-1:0] rd_latch = '0;

  assign mem_dat = mem_re ? rd_latch : {DATA_W{1'bz}};

  always @(negedge mclk) begin
    if (mem_en) begin
      for (int k = 0; k < DATA_W / 8; k++) begin
        if (mem_we) mem[mem_addr_sel + 32'(k)] = mem_dat[8*k +: 8];
        if (mem_re) rd_latch[8*k +: 8] = mem.exists(mem_addr_sel + 32'(k)) ?
                                         mem[mem_addr_sel + 32'(k)] : 8'h00;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         err;
    int           due;
    int           mclk0;
    int           en0;
  } exp_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] exp_rdata;
    logic         exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   mclk_rises = 0;
  int   en_cycles  = 0;

  always @(posedge mclk) mclk_rises++;

  // Per-cycle bus monitor and response scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("re_we_exclusive", mem_re & mem_we, 1'b0);
      if (mem_en) en_cycles++;
      if (sb.size() != 0 && mem_en) begin
        check("bus_addr", mem_addr_sel, sb[0].addr);
        check("bus_dir", {mem_we, mem_re}, sb[0].we ? 2'b10 : 2'b01);
        if (sb[0].we) check("bus_wdata", mem_dat, sb[0].wdata);
      end
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("rsp_cycle", cyc, e.due);
          check("rsp_err", rsp_err, e.err);
          check("rsp_rdata", rsp_rdata, e.rdata);
          check("mclk_pulses", mclk_rises - e.mclk0, e.err ? 0 : 1);
          check("mem_en_cycles", en_cycles - e.en0, e.err ? 0 : 2 + 2 * MCLK_HALF);
          check("rsp_ready_low", req_ready, 1'b0);
          check("rsp_busy", busy, 1'b1);
          if (e.we) check("bus_released", mem_dat !== e.wdata, 1'b1);
        end
      end
    end
  end

  // Drive one request; returns the accept edge number (value of cyc after it).
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [127:0] wdata, input logic [127:0] exp_rdata,
                       input logic exp_err, input bit keep_valid, input bit track,
                       output int acc_edge);
    exp_t e;
    int   waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    acc_edge = -1;
    if (!req_ready) begin
      check("ready_timeout", req_ready, 1'b1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    acc_edge  = cyc + 1;
    if (track) begin
      e.we    = we;
      e.addr  = addr;
      e.wdata = wdata;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.due   = acc_edge + (exp_err ? 0 : LAT);
      e.mclk0 = mclk_rises;
      e.en0   = en_cycles;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    // Scramble the request after acceptance: the controller must have latched it.
    req_we    = ~we;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb.size() != 0 || !req_ready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_done", sb.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, acc;
    int waited;
    logic [31:0] b2b_addr2;
    logic [127:0] b2b_exp1;

    for (int k = 0; k < 16; k++) mem[32'(k)] = 8'(k);

`ifdef MEMCTL_ALIGN_CHECK_EN
    vecs[0] = '{1'b0, 32'h0000_0000, '0, V0, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0013, '0, V0, 1'b1};
    vecs[2] = '{1'b1, 32'h0000_0020, DB, V0, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0020, '0, DB, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_0025, W2, DB, 1'b1};
    vecs[5] = '{1'b0, 32'h0000_0020, '0, DB, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0010, '0, '0, 1'b0};
    b2b_exp1  = V0;
    b2b_addr2 = 32'h0000_0020;
`else
    vecs[0] = '{1'b0, 32'h0000_0000, '0, V0, 1'b0};
    vecs[1] = '{1'b1, 32'h0001_01FF, DB, V0, 1'b0};
    vecs[2] = '{1'b0, 32'h0001_01FF, '0, DB, 1'b0};
    vecs[3] = '{1'b0, 32'h0000_0008, '0, V3, 1'b0};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, W2, V3, 1'b0};
    vecs[5] = '{1'b0, 32'hFFFF_FFF8, '0, W2, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0000, '0, V6, 1'b0};
    b2b_exp1  = V6;
    b2b_addr2 = 32'h0001_01FF;
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    check("rst_bus", {mclk, mem_en, mem_we, mem_re}, 4'b0000);
    check("rst_addr", mem_addr_sel, '0);

    // Table-driven requests.
    for (int i = 0; i < 7; i++)
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata,
            vecs[i].exp_err, 1'b0, 1'b1, acc);
    drain();
    if (!ALIGN_EN)
      check("mem_101ff", mem.exists(32'h0001_01FF) ? mem[32'h0001_01FF] : 8'hXX, 8'hEF);
    check("idle_mclk_low", mclk, 1'b0);

    // Back-to-back: req_valid held high across two reads.
    issue(1'b0, 32'h0000_0000, '0, b2b_exp1, 1'b0, 1'b1, 1'b1, acc1);
    issue(1'b0, b2b_addr2, '0, DB, 1'b0, 1'b0, 1'b1, acc2);
    check("b2b_gap", acc2 - acc1, LAT + 2);
    drain();

    // Reset in the middle of a write, while mclk is high.
    issue(1'b1, 32'h0000_2000, {4{32'hA5A55A5A}}, '0, 1'b0, 1'b0, 1'b0, acc);
    waited = 0;
    while (!mclk && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("reached_high", mclk, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_bus", {mclk, mem_en, mem_we, mem_re}, 4'b0000);
    check("midrst_addr", mem_addr_sel, '0);
    check("midrst_ready", req_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_released", mem_dat !== {4{32'hA5A55A5A}}, 1'b1);
    for (int i = 0; i < LAT + 4; i++) begin
      check("midrst_no_rsp", rsp_valid, 1'b0);
      @(negedge clk);
    end

    // A read after the aborted write completes normally.
    issue(1'b0, b2b_addr2, '0, DB, 1'b0, 1'b0, 1'b1, acc);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
